// File: rtl/fwd_pkg.sv
// Shared definitions for the operand forwarding / hazard unit:
// default sizes, forwarding source encoding and the stall FSM states.
package fwd_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_REG_AW    = 5;
  localparam int DEF_NUM_RD    = 2;
  localparam int DEF_NUM_STG   = 2;
  localparam int DEF_MAX_STALL = 4;

  // Source code 0 means "register file"; stage k is reported as k+1.
  localparam int SRC_REGFILE = 0;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_STALLED = 1'b1
  } fwd_state_e;

  // Source code reported for a forwarding hit in stage k.
  function automatic int stage_src(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Operand selection for one read port: picks the youngest pipeline stage
// writing the requested register, otherwise the register-file data.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_STG = DEF_NUM_STG,
  parameter int SRC_W   = $clog2(NUM_STG + 1)
) (
  input  logic                             i_rd_en,
  input  logic [REG_AW-1:0]                i_rd_num,
  input  logic [DATA_W-1:0]                i_rd_rfdata,
  input  logic [NUM_STG-1:0]               i_stg_we,
  input  logic [NUM_STG-1:0]               i_stg_pending,
  input  logic [NUM_STG-1:0][REG_AW-1:0]   i_stg_waddr,
  input  logic [NUM_STG-1:0][DATA_W-1:0]   i_stg_wdata,
  output logic [DATA_W-1:0]                o_sel_data,
  output logic [SRC_W-1:0]                 o_sel_src,
  output logic                             o_sel_pending
);

  // Walk oldest to youngest so the youngest match overrides; register 0
  // never forwards, so it always falls through to the register file.
  always_comb begin
    o_sel_data    = i_rd_rfdata;
    o_sel_src     = SRC_W'(SRC_REGFILE);
    o_sel_pending = 1'b0;
    if (i_rd_en && (i_rd_num != '0)) begin
      for (int k = NUM_STG - 1; k >= 0; k--) begin
        if (i_stg_we[k] && (i_stg_waddr[k] == i_rd_num)) begin
          o_sel_data    = i_stg_wdata[k];
          o_sel_src     = SRC_W'(stage_src(k));
          o_sel_pending = i_stg_pending[k];
        end
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use hazard detection. stall is combinational;
// resolved operands are registered and hold while stalled. A stall FSM
// tracks consecutive stall cycles and raises a sticky error at the limit.
// Handshake: the pipeline treats stall=1 as "not ready" for the current
// operand set; fwd_data/fwd_src accept a new set only on edges with stall=0.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int NUM_STG   = DEF_NUM_STG,
  parameter int MAX_STALL = DEF_MAX_STALL,
  parameter int SRC_W     = $clog2(NUM_STG + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_STG-1:0]               stg_we,
  input  logic [NUM_STG-1:0]               stg_pending,
  input  logic [NUM_STG-1:0][REG_AW-1:0]   stg_waddr,
  input  logic [NUM_STG-1:0][DATA_W-1:0]   stg_wdata,
  input  logic [NUM_RD-1:0]                rd_en,
  input  logic [NUM_RD-1:0][REG_AW-1:0]    rd_num,
  input  logic [NUM_RD-1:0][DATA_W-1:0]    rd_rfdata,
  output logic                             stall,
  output logic [NUM_RD-1:0][DATA_W-1:0]    fwd_data,
  output logic [NUM_RD-1:0][SRC_W-1:0]     fwd_src,
  output logic [31:0]                      stall_cnt,
  output logic                             stall_err,
  output fwd_state_e                       dbg_state
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);

  logic [NUM_RD-1:0][DATA_W-1:0] w_sel_data;
  logic [NUM_RD-1:0][SRC_W-1:0]  w_sel_src;
  logic [NUM_RD-1:0]             w_sel_pending;

  fwd_state_e                    r_state;
  logic [CNT_W-1:0]              r_consec;
  logic                          r_err;
  logic [31:0]                   r_stall_cnt;
  logic [NUM_RD-1:0][DATA_W-1:0] r_fwd_data;
  logic [NUM_RD-1:0][SRC_W-1:0]  r_fwd_src;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_sel #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .NUM_STG (NUM_STG),
      .SRC_W   (SRC_W)
    ) u_sel (
      .i_rd_en       (rd_en[p]),
      .i_rd_num      (rd_num[p]),
      .i_rd_rfdata   (rd_rfdata[p]),
      .i_stg_we      (stg_we),
      .i_stg_pending (stg_pending),
      .i_stg_waddr   (stg_waddr),
      .i_stg_wdata   (stg_wdata),
      .o_sel_data    (w_sel_data[p]),
      .o_sel_src     (w_sel_src[p]),
      .o_sel_pending (w_sel_pending[p])
    );
  end

  // Stall only when a port's chosen source is still waiting on its result.
  assign stall = |w_sel_pending;

  // Stall FSM with its registered outputs: operand capture, stall counters, error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_consec    <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_fwd_data  <= '0;
      r_fwd_src   <= '0;
    end else if (stall) begin
      r_state <= ST_STALLED;
      if (r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (r_consec != CNT_W'(MAX_STALL)) r_consec <= r_consec + CNT_W'(1);
      // This stall cycle brings the run length to the limit.
      if (r_consec >= CNT_W'(MAX_STALL - 1)) r_err <= 1'b1;
    end else begin
      r_state    <= ST_RUN;
      r_consec   <= '0;
      r_fwd_data <= w_sel_data;
      r_fwd_src  <= w_sel_src;
    end
  end

  assign fwd_data  = r_fwd_data;
  assign fwd_src   = r_fwd_src;
  assign stall_cnt = r_stall_cnt;
  assign stall_err = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed scenarios followed by random
// traffic, all checked against a behavioural model of the forwarding rules.
module tb_forward_hazard_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NS = 2;
  localparam int MS = 4;
  localparam int SW = $clog2(NS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NS-1:0]         stg_we;
  logic [NS-1:0]         stg_pending;
  logic [NS-1:0][AW-1:0] stg_waddr;
  logic [NS-1:0][DW-1:0] stg_wdata;
  logic [NR-1:0]         rd_en;
  logic [NR-1:0][AW-1:0] rd_num;
  logic [NR-1:0][DW-1:0] rd_rfdata;
  logic                  stall;
  logic [NR-1:0][DW-1:0] fwd_data;
  logic [NR-1:0][SW-1:0] fwd_src;
  logic [31:0]           stall_cnt;
  logic                  stall_err;
  logic [0:0]            dbg_state;

  forward_hazard_unit #(
    .DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .NUM_STG(NS), .MAX_STALL(MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stg_we      (stg_we),
    .stg_pending (stg_pending),
    .stg_waddr   (stg_waddr),
    .stg_wdata   (stg_wdata),
    .rd_en       (rd_en),
    .rd_num      (rd_num),
    .rd_rfdata   (rd_rfdata),
    .stall       (stall),
    .fwd_data    (fwd_data),
    .fwd_src     (fwd_src),
    .stall_cnt   (stall_cnt),
    .stall_err   (stall_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] m_data [NR];
  logic [SW-1:0] m_src  [NR];
  logic [31:0]   m_cnt;
  int            m_consec;
  logic          m_err;
  logic          m_stalled;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Which stage feeds port p: -1 for the register file, else the stage index.
  function automatic int pick(input int p);
    if (!rd_en[p] || rd_num[p] == 0) return -1;
    for (int k = 0; k < NS; k++)
      if (stg_we[k] && stg_waddr[k] == rd_num[p]) return k;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    stg_we = '0; stg_pending = '0; stg_waddr = '0; stg_wdata = '0;
    rd_en = '0; rd_num = '0; rd_rfdata = '0;
  endtask

  task automatic set_stage(input int k, input logic we, input logic pend,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    stg_we[k] = we; stg_pending[k] = pend; stg_waddr[k] = a; stg_wdata[k] = d;
  endtask

  task automatic set_port(input int p, input logic en, input logic [AW-1:0] n,
                          input logic [DW-1:0] rf);
    rd_en[p] = en; rd_num[p] = n; rd_rfdata[p] = rf;
  endtask

  // One clock with the currently driven inputs: check the combinational
  // stall mid-cycle, then advance the model and check registered outputs.
  task automatic cycle();
    logic          exp_stall;
    logic [DW-1:0] nd [NR];
    logic [SW-1:0] nsrc [NR];
    int            k;
    exp_stall = 1'b0;
    for (int p = 0; p < NR; p++) begin
      k = pick(p);
      if (k < 0) begin
        nd[p] = rd_rfdata[p]; nsrc[p] = '0;
      end else begin
        nd[p] = stg_wdata[k]; nsrc[p] = SW'(k + 1);
        if (stg_pending[k]) exp_stall = 1'b1;
      end
    end
    #2;
    chk("stall", stall, exp_stall);
    @(posedge clk); #1;
    if (rst) begin
      for (int p = 0; p < NR; p++) begin m_data[p] = '0; m_src[p] = '0; end
      m_cnt = 0; m_consec = 0; m_err = 0; m_stalled = 0;
    end else if (exp_stall) begin
      m_stalled = 1;
      m_consec++;
      if (m_consec >= MS) m_err = 1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end else begin
      m_stalled = 0;
      m_consec = 0;
      for (int p = 0; p < NR; p++) begin m_data[p] = nd[p]; m_src[p] = nsrc[p]; end
    end
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("fwd_data%0d", p), fwd_data[p], m_data[p]);
      chk($sformatf("fwd_src%0d", p), fwd_src[p], m_src[p]);
    end
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("stall_err", stall_err, m_err);
    chk("state", dbg_state, m_stalled);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int p = 0; p < NR; p++) begin m_data[p] = 'x; m_src[p] = 'x; end
    m_cnt = 'x; m_consec = 0; m_err = 1'bx; m_stalled = 1'bx;
    clr_inputs();
    rst = 1'b1;
    cycle();
    chk("reset_data0", fwd_data[0], 32'h0);
    chk("reset_cnt", stall_cnt, 32'h0);
    chk("reset_err", stall_err, 1'b0);
    rst = 1'b0;

    // Youngest stage wins when both stages write the register.
    set_stage(0, 1, 0, 5'd3, 32'h11);
    set_stage(1, 1, 0, 5'd3, 32'h22);
    set_port(0, 1, 5'd3, 32'hAAAA);
    set_port(1, 1, 5'd7, 32'hBBBB);
    cycle();
    chk("yng_data", fwd_data[0], 32'h11);
    chk("yng_src", fwd_src[0], 2'd1);
    chk("rf_data1", fwd_data[1], 32'hBBBB);

    // Only the older stage matches.
    set_stage(0, 1, 0, 5'd9, 32'h33);
    cycle();
    chk("old_src", fwd_src[0], 2'd2);
    chk("old_data", fwd_data[0], 32'h22);

    // Register 0 never forwards and never stalls.
    clr_inputs();
    set_stage(0, 1, 1, 5'd0, 32'h44);
    set_port(1, 1, 5'd0, 32'hC0DE);
    cycle();
    chk("r0_data", fwd_data[1], 32'hC0DE);
    chk("r0_src", fwd_src[1], 2'd0);

    // Pending older stage shadowed by a younger ready match: no stall.
    clr_inputs();
    set_stage(0, 1, 0, 5'd6, 32'h66);
    set_stage(1, 1, 1, 5'd6, 32'h77);
    set_port(0, 1, 5'd6, 32'h0);
    cycle();
    chk("shadow_data", fwd_data[0], 32'h66);

    // Two-cycle load-use stall: outputs hold, counter reaches 2.
    clr_inputs();
    set_stage(0, 1, 1, 5'd5, 32'h55);
    set_port(0, 1, 5'd5, 32'h0);
    cycle();
    cycle();
    chk("ls_hold", fwd_data[0], 32'h66);
    chk("ls_cnt", stall_cnt, 32'd2);
    stg_pending[0] = 1'b0;
    cycle();
    chk("ls_run", dbg_state, 1'b0);
    chk("ls_data", fwd_data[0], 32'h55);

    // Stall run of MAX_STALL cycles makes the error sticky.
    stg_pending[0] = 1'b1;
    for (int i = 0; i < MS; i++) cycle();
    chk("err_set", stall_err, 1'b1);
    stg_pending[0] = 1'b0;
    cycle();
    cycle();
    chk("err_sticky", stall_err, 1'b1);

    // Reset in the middle of a stall run.
    rst = 1'b1; cycle(); rst = 1'b0;
    stg_pending[0] = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("mid_cnt3", stall_cnt, 32'd3);
    rst = 1'b1;
    cycle();
    chk("mid_cnt0", stall_cnt, 32'd0);
    chk("mid_state", dbg_state, 1'b0);
    chk("mid_data", fwd_data[0], 32'h0);
    rst = 1'b0;

    // Random traffic over a small register window to force frequent hits.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NS; k++)
        set_stage(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                  AW'($urandom_range(0, 3)), $urandom);
      for (int p = 0; p < NR; p++)
        set_port(p, 1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)), $urandom);
      rst = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
